key_set_ctrl: RTL and testbench

KEY_SET_CTRL -- requirements
Module: key_set_ctrl

---
 rtl/key_set_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_key_set_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/key_set_ctrl.sv
// Time-set key controller: three debounced push-key channels emitting single-cycle
// increment pulses. Define KEY_SET_AUTO_REPEAT_EN to add hold-to-repeat pulses.

// One key channel: synchronizer, debounce FSM and optional repeat timer.
//   state       | meaning
//   IDLE        | key released and debounced
//   PRESS_DEB   | key seen pressed, waiting for a stable press
//   HELD        | press accepted, key still down
//   RELEASE_DEB | key seen released, waiting for a stable release
module key_set_chan #(
  parameter int CNT_W      = 25,
  parameter int DEB_CYCLES = 1000000
`ifdef KEY_SET_AUTO_REPEAT_EN
  ,
  parameter int RPT_DELAY_CYCLES  = 25000000,
  parameter int RPT_PERIOD_CYCLES = 10000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pulse,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, RELEASE_DEB} state_t;

  localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [1:0]         sync_q, sync_d;
  logic [CNT_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic               key;
  logic               accept;

  // Inverted at the input so the reset value of the synchronizer means released.
  assign sync_d = {sync_q[0], ~key_n};
  assign key    = sync_q[1];

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (key) begin
          state_d   = PRESS_DEB;
          deb_cnt_d = DEB_LOAD;
        end
      end
      PRESS_DEB: begin
        if (!key) begin
          state_d = IDLE;
        end else if (deb_cnt_q == '0) begin
          state_d = HELD;
          accept  = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q - CNT_ONE;
        end
      end
      HELD: begin
        if (!key) begin
          state_d   = RELEASE_DEB;
          deb_cnt_d = DEB_LOAD;
        end
      end
      RELEASE_DEB: begin
        if (key) begin
          state_d = HELD;
        end else if (deb_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= 2'b00;
      deb_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign busy = (state_q != IDLE);

`ifdef KEY_SET_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY_LOAD  = CNT_W'(RPT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_PERIOD_LOAD = CNT_W'(RPT_PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_fire;

  // Keeps running through RELEASE_DEB so a release bounce does not restart it.
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_fire  = 1'b0;
    if (accept) begin
      rpt_cnt_d = RPT_DELAY_LOAD;
    end else if (state_q == HELD || state_q == RELEASE_DEB) begin
      if (rpt_cnt_q == '0) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = RPT_PERIOD_LOAD;
      end else begin
        rpt_cnt_d = rpt_cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign pulse = accept | rpt_fire;
`else
  assign pulse = accept;
`endif

endmodule

module key_set_ctrl #(
  parameter int DEB_CYCLES        = 1000000,
  parameter int RPT_DELAY_CYCLES  = 25000000,
  parameter int RPT_PERIOD_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic cset,
  input  logic h,
  input  logic m,
  input  logic s,
  output logic h_inc,
  output logic m_inc,
  output logic s_inc,
  output logic key_busy
);

  localparam int MAX_A = (DEB_CYCLES > RPT_DELAY_CYCLES) ? DEB_CYCLES : RPT_DELAY_CYCLES;
  localparam int MAX_P = (MAX_A > RPT_PERIOD_CYCLES) ? MAX_A : RPT_PERIOD_CYCLES;
  localparam int CNT_W = $clog2(MAX_P + 1);

  logic [2:0] key_n;
  logic [2:0] pulse;
  logic [2:0] busy;

  assign key_n = {h, m, s};

  for (genvar i = 0; i < 3; i++) begin : g_chan
    key_set_chan #(
      .CNT_W            (CNT_W),
      .DEB_CYCLES       (DEB_CYCLES)
`ifdef KEY_SET_AUTO_REPEAT_EN
      ,
      .RPT_DELAY_CYCLES (RPT_DELAY_CYCLES),
      .RPT_PERIOD_CYCLES(RPT_PERIOD_CYCLES)
`endif
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .key_n(key_n[i]),
      .pulse(pulse[i]),
      .busy (busy[i])
    );
  end

  // cset only gates the outputs; the channels keep tracking the keys regardless.
  assign h_inc    = pulse[2] & cset;
  assign m_inc    = pulse[1] & cset;
  assign s_inc    = pulse[0] & cset;
  assign key_busy = |busy;

endmodule

// File: tb/tb_key_set_ctrl.sv
// Scoreboard bench for key_set_ctrl: a run-length debounce model predicts every
// cycle's {h_inc, m_inc, s_inc, key_busy}; a negedge monitor compares.
module tb_key_set_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
`ifdef KEY_SET_AUTO_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, cset, h, m, s;
  logic h_inc, m_inc, s_inc, key_busy;

  key_set_ctrl #(
    .DEB_CYCLES       (DEB),
    .RPT_DELAY_CYCLES (RD),
    .RPT_PERIOD_CYCLES(RP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cset    (cset),
    .h       (h),
    .m       (m),
    .s       (s),
    .h_inc   (h_inc),
    .m_inc   (m_inc),
    .s_inc   (s_inc),
    .key_busy(key_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       edge_no;
    logic [3:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   edge_n  = 0;

  // Model: per key a debounced level, the run length of samples disagreeing with
  // it, the edge at which the press was accepted, and the 2-deep sample history.
  bit mlvl[3];
  int mrun[3];
  int macc[3];
  bit p1[3];
  bit p2[3];

  task automatic model_edge(input bit r, input bit cs, input bit [2:0] ak);
    exp_t ex;
    bit   pl;
    bit   ks;
    bit   busy_any;
    int   dt;
    ex.edge_no = edge_n;
    ex.v       = 4'b0000;
    busy_any   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pl = 1'b0;
      if (r) begin
        mlvl[i] = 1'b0;
        mrun[i] = 0;
        p1[i]   = 1'b0;
        p2[i]   = 1'b0;
      end else begin
        ks = p2[i];
        if (mlvl[i] || mrun[i] > 0) busy_any = 1'b1;
        dt = edge_n - macc[i];
        if (RPT_EN && mlvl[i] && dt >= RD && ((dt - RD) % RP) == 0) pl = 1'b1;
        if (ks != mlvl[i]) begin
          mrun[i]++;
          if (mrun[i] == DEB + 1) begin
            mlvl[i] = ks;
            mrun[i] = 0;
            if (ks) begin
              pl      = 1'b1;
              macc[i] = edge_n;
            end
          end
        end else begin
          mrun[i] = 0;
        end
        p2[i] = p1[i];
        p1[i] = ak[2-i];
      end
      ex.v[3-i] = pl & cs & ~r;
    end
    ex.v[0] = busy_any;
    exp_q.push_back(ex);
  endtask

  // kn is the raw active-low {h, m, s}; values apply to the next rising edge.
  task automatic cycle(input bit r, input bit cs, input bit [2:0] kn);
    @(posedge clk);
    #1;
    rst  = r;
    cset = cs;
    h    = kn[2];
    m    = kn[1];
    s    = kn[0];
    edge_n++;
    model_edge(r, cs, ~kn);
  endtask

  task automatic run(input int n, input bit r, input bit cs, input bit [2:0] kn);
    for (int k = 0; k < n; k++) cycle(r, cs, kn);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if ({h_inc, m_inc, s_inc, key_busy} !== e.v) begin
        errors++;
        $display("FAIL outputs edge %0d: {h_inc,m_inc,s_inc,key_busy} got %b expected %b",
                 e.edge_no, {h_inc, m_inc, s_inc, key_busy}, e.v);
      end
    end
  end

  bit       rlvl[3];
  int       rlen[3];
  bit       rcs;
  bit [2:0] rkn;

  initial begin
    rst  = 1'b1;
    cset = 1'b0;
    h    = 1'b1;
    m    = 1'b1;
    s    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mlvl[i] = 1'b0;
      mrun[i] = 0;
      macc[i] = 0;
      p1[i]   = 1'b0;
      p2[i]   = 1'b0;
    end

    run(3, 1'b1, 1'b0, 3'b111);
    // single h press, held then released
    run(8, 1'b0, 1'b1, 3'b011);
    run(10, 1'b0, 1'b1, 3'b111);
    // short m bounces that never reach acceptance
    for (int k = 0; k < 5; k++) begin
      run(3, 1'b0, 1'b1, 3'b101);
      run(3, 1'b0, 1'b1, 3'b111);
    end
    run(4, 1'b0, 1'b1, 3'b111);
    // s press with cset low
    run(20, 1'b0, 1'b0, 3'b110);
    run(10, 1'b0, 1'b0, 3'b111);
    // long h hold for auto-repeat
    run(30, 1'b0, 1'b1, 3'b011);
    run(12, 1'b0, 1'b1, 3'b111);
    // h and s pressed together
    run(10, 1'b0, 1'b1, 3'b010);
    run(10, 1'b0, 1'b1, 3'b111);
    // reset in the middle of an h press, key still held afterwards
    run(4, 1'b0, 1'b1, 3'b011);
    run(2, 1'b1, 1'b1, 3'b011);
    run(10, 1'b0, 1'b1, 3'b011);
    run(10, 1'b0, 1'b1, 3'b111);

    // randomized bouncing keys, cset changes and occasional resets
    for (int i = 0; i < 3; i++) begin
      rlvl[i] = 1'b0;
      rlen[i] = $urandom_range(1, 14);
    end
    rcs = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (rlen[i] == 0) begin
          rlvl[i] = ~rlvl[i];
          rlen[i] = $urandom_range(1, 14);
        end
        rlen[i]--;
        rkn[2-i] = ~rlvl[i];
      end
      if ($urandom_range(0, 19) == 0) rcs = ~rcs;
      cycle(($urandom_range(0, 299) == 0), rcs, rkn);
    end
    run(12, 1'b0, 1'b1, 3'b111);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
